// File: rtl/calc_pkg.sv
// Shared constants for the calc datapath.
// Pure parameter package, no logic.
// No flow control involved.
package calc_pkg;
  localparam int DATA_W  = 32;
  localparam int EXT_W   = 34;
  localparam int SHIFT_W = 2;
  // The adder is one bit wider than a term. Four terms of +2^31 add up to
  // +2^33, which a 34-bit signed value cannot hold. With FUNC=3 that one
  // case would otherwise come out with the wrong sign after the shift.
  localparam int SUM_W   = EXT_W + 1;
endpackage

// File: rtl/calc_term.sv
// Conditional negate of one operand after sign extension to EXT_W bits.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of its inputs.
module calc_term
  import calc_pkg::*;
(
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_neg,
  output logic [EXT_W-1:0]  o_term
);

  logic [EXT_W-1:0] w_ext;

  // Extend before negating, so that -(-2^31) = +2^31 is representable.
  assign w_ext  = {{(EXT_W-DATA_W){i_dat[DATA_W-1]}}, i_dat};
  assign o_term = i_neg ? (~w_ext + {{(EXT_W-1){1'b0}}, 1'b1}) : w_ext;

endmodule

// File: rtl/calc_unit.sv
// Signed sum of four +/- operands, arithmetic right shift, 32-bit wrap.
// Latency: 2 register stages (terms+FUNC, then sum/shift into out_o).
// Backpressure: none, a new operand set is accepted every cycle.
module calc_unit
  import calc_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [DATA_W-1:0]  inpa_i,
  input  logic [DATA_W-1:0]  inpb_i,
  input  logic [DATA_W-1:0]  inpc_i,
  input  logic [DATA_W-1:0]  inpd_i,
  input  logic               A,
  input  logic               B,
  input  logic               C,
  input  logic               D,
  input  logic [SHIFT_W-1:0] FUNC,
  output logic [DATA_W-1:0]  out_o
);

  logic [DATA_W-1:0]        w_inp  [4];
  logic                     w_neg  [4];
  logic [EXT_W-1:0]         w_term [4];
  logic [EXT_W-1:0]         r_term [4];
  logic [SHIFT_W-1:0]       r_func;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_shift;
  logic [DATA_W-1:0]        r_out;

  assign w_inp[0] = inpa_i;
  assign w_inp[1] = inpb_i;
  assign w_inp[2] = inpc_i;
  assign w_inp[3] = inpd_i;
  assign w_neg[0] = A;
  assign w_neg[1] = B;
  assign w_neg[2] = C;
  assign w_neg[3] = D;

  for (genvar g = 0; g < 4; g++) begin : g_term
    calc_term u_term (
      .i_dat  (w_inp[g]),
      .i_neg  (w_neg[g]),
      .o_term (w_term[g])
    );
  end

  // Stage 1: capture the signed terms together with their FUNC.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 4; i++) r_term[i] <= '0;
      r_func <= '0;
    end else begin
      for (int i = 0; i < 4; i++) r_term[i] <= w_term[i];
      r_func <= FUNC;
    end
  end

  // Exact sum of the stage-1 terms, then a floor (sign-preserving) shift.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 4; i++) begin
      w_sum = w_sum + signed'({r_term[i][EXT_W-1], r_term[i]});
    end
    w_shift = w_sum >>> r_func;
  end

  // Stage 2: keep the low word of the shifted sum. Wrap, no saturation.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) r_out <= '0;
    else            r_out <= w_shift[DATA_W-1:0];
  end

  assign out_o = r_out;

endmodule

// File: tb/tb_calc_unit.sv
// Directed bench for calc_unit: the driver queues the expected results and
// the monitor compares out_o once per cycle, one register stage after capture.
module tb_calc_unit;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [31:0] inpa_i = '0, inpb_i = '0, inpc_i = '0, inpd_i = '0;
  logic        A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic [1:0]  FUNC = '0;
  logic [31:0] out_o;

  calc_unit dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inpa_i    (inpa_i),
    .inpb_i    (inpb_i),
    .inpc_i    (inpc_i),
    .inpd_i    (inpd_i),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .FUNC      (FUNC),
    .out_o     (out_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cap;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    edge_cnt = 0;
  int    n_cmp    = 0;
  int    n_bad    = 0;

  // Monitor: count edges and compare out_o 1 ns after each one.
  // Inputs captured at edge c appear on out_o after edge c+1.
  // A reset sampled at the comparing edge forces the expected value to 0.
  item_t       m_it;
  logic        m_rst;
  logic [31:0] m_exp;
  initial begin
    forever begin
      @(posedge clk_i);
      edge_cnt++;
      m_rst = reset_n_i;
      #1;
      if (sb.size() > 0 && sb[0].cap == edge_cnt - 1) begin
        m_it  = sb.pop_front();
        m_exp = m_rst ? m_it.exp : 32'd0;
        n_cmp++;
        if (out_o !== m_exp) begin
          n_bad++;
          $display("FAIL cap_edge%0d out_o: got %h required %h", m_it.cap, out_o, m_exp);
        end
      end
    end
  end

  // Driver: apply one operand set at the negedge and queue its expected result.
  // fl = {A,B,C,D}. Vectors applied while reset is low are expected to give 0.
  task automatic apply(input bit rst_n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d,
                       input logic [3:0] fl, input logic [1:0] fn,
                       input logic [31:0] exp);
    item_t it;
    @(negedge clk_i);
    reset_n_i = rst_n;
    inpa_i = a; inpb_i = b; inpc_i = c; inpd_i = d;
    A = fl[3]; B = fl[2]; C = fl[1]; D = fl[0];
    FUNC = fn;
    it.cap = edge_cnt + 1;
    it.exp = rst_n ? exp : 32'd0;
    sb.push_back(it);
  endtask

  initial begin
    // Reset held for 3 cycles with live inputs. 5+6+7+8 = 26 after release.
    repeat (3) apply(1'b0, 32'd5, 32'd6, 32'd7, 32'd8, 4'b0000, 2'd0, 32'd0);
    repeat (2) apply(1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 4'b0000, 2'd0, 32'd26);

    // Plain add. The preceding zero vector means 10 must not show up early.
    apply(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd0, 32'd0);
    apply(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0000, 2'd0, 32'd10);
    apply(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd0, 32'd0);

    // Inversion: -1+2-3+4 = 2.
    apply(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 4'b1010, 2'd0, 32'd2);
    // Floor shifts: -7>>>1 = -4, 100>>>2 = 25, -4>>>3 = -1.
    apply(1'b1, -32'sd7, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd1, 32'hFFFF_FFFC);
    apply(1'b1, 32'd100, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd2, 32'd25);
    apply(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          4'b0000, 2'd3, 32'hFFFF_FFFF);

    // Wide sum: 4*(2^31-1) = 2^33-4 wraps to 0xFFFFFFFC; >>>2 gives 2^31-1.
    apply(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
          4'b0000, 2'd0, 32'hFFFF_FFFC);
    apply(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
          4'b0000, 2'd2, 32'h7FFF_FFFF);
    // Most negative sum: 4*(-2^31) = -2^33, >>>3 = -2^30.
    apply(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
          4'b0000, 2'd3, 32'hC000_0000);

    // Negation edge: -(-2^31) = +2^31 -> 0x80000000; >>>1 gives 0x40000000.
    apply(1'b1, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 4'b1000, 2'd0, 32'h8000_0000);
    apply(1'b1, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 4'b1000, 2'd1, 32'h4000_0000);

    // Mixed: 9 - 4 - (-2) + 1 = 8, >>>1 = 4.
    apply(1'b1, 32'd9, 32'd4, 32'hFFFF_FFFE, 32'd1, 4'b0110, 2'd1, 32'd4);

    // Back-to-back flag toggling on A: each result follows its own A.
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 32'd3, 32'd0, 32'd0, 32'd0, {i[0], 3'b000}, 2'd0,
            i[0] ? 32'hFFFF_FFFD : 32'd3);
    end

    // Reset in mid-stream: the in-flight 10 is dropped, refill yields 0, then 20.
    apply(1'b1, 32'd10, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd0, 32'd10);
    apply(1'b0, 32'd11, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd0, 32'd0);
    apply(1'b1, 32'd20, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd0, 32'd20);
    apply(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0000, 2'd0, 32'd0);

    // Drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk_i);
    @(negedge clk_i);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
